// File: rtl/uart_serial_pkg.sv
// Shared types and helpers for the parametrised UART transceiver core.
// Frame parity is computed over the low (nbits_code + 5) bits of a byte.
package uart_serial_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_word_t;

    localparam int WORD_W = $bits(rx_word_t);

    // XOR of the active data bits; nbits is the data width minus 5.
    function automatic logic parity_of(input logic [7:0] data, input logic [1:0] nbits);
        logic [7:0] mask;
        mask = 8'hff >> (2'd3 - nbits);
        return ^(data & mask);
    endfunction

    // Encoding 2'b11 is deliberately treated as "no parity".
    function automatic logic parity_enabled(input logic [1:0] par);
        return (par == PAR_EVEN) || (par == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_serial_rx_fifo.sv
// First-word-fall-through receive FIFO of rx_word_t entries.
// A pop and a push in the same clock both succeed even when full.
module uart_serial_rx_fifo
    import uart_serial_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              push_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    rx_word_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata_i;
    end

endmodule

// File: rtl/uart_serial_xcvr.sv
// UART transceiver: tick generator, TX and RX framers with runtime config,
// receive FIFO with per-byte parity/framing status and sticky overrun.
module uart_serial_xcvr
    import uart_serial_pkg::*;
#(
    parameter int DIV_W         = 16,
    parameter int OVERSAMPLE    = 16,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic [1:0]       cfg_nbits_i,
    input  logic [1:0]       cfg_parity_i,
    input  logic             cfg_stop2_i,
    input  logic [7:0]       tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic             tx_busy_o,
    output logic             stx_o,
    input  logic             srx_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_parity_err_o,
    output logic             rx_frame_err_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             rx_overrun_o
);

    localparam int            CW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);

    // Divisor is re-latched only at a wrap so a change never truncates a tick period.
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_q;
    logic             tick;

    assign tick = (div_cnt == div_q);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            div_cnt <= '0;
            div_q   <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            div_q   <= cfg_div_i;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    logic [1:0] srx_sync;
    logic       rx_s;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) srx_sync <= 2'b11;
        else         srx_sync <= {srx_sync[0], srx_i};
    end

    assign rx_s = srx_sync[1];

    // ---------------- transmitter ----------------
    tx_state_e     tx_state;
    logic          tx_first;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic [1:0]    tx_nbits;
    logic [1:0]    tx_par_cfg;
    logic          tx_stop2;
    logic          tx_stop_idx;
    logic          tx_par_bit;
    logic          stx_q;
    logic          tx_ready_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_state    <= TX_IDLE;
            tx_first    <= 1'b0;
            tx_cnt      <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            tx_nbits    <= '0;
            tx_par_cfg  <= '0;
            tx_stop2    <= 1'b0;
            tx_stop_idx <= 1'b0;
            tx_par_bit  <= 1'b0;
            stx_q       <= 1'b1;
            tx_ready_q  <= 1'b1;
        end else if (tx_state == TX_IDLE) begin
            if (tx_valid_i) begin
                tx_shift   <= tx_data_i;
                tx_nbits   <= cfg_nbits_i;
                tx_par_cfg <= cfg_parity_i;
                tx_stop2   <= cfg_stop2_i;
                tx_par_bit <= parity_of(tx_data_i, cfg_nbits_i) ^ (cfg_parity_i == PAR_ODD);
                tx_first   <= 1'b1;
                tx_ready_q <= 1'b0;
                tx_state   <= TX_START;
            end
        end else if (tick) begin
            // The start bit begins on the first tick after accept, not at accept.
            if (tx_first) begin
                stx_q    <= 1'b0;
                tx_first <= 1'b0;
                tx_cnt   <= '0;
            end else if (tx_cnt != CNT_LAST) begin
                tx_cnt <= tx_cnt + 1'b1;
            end else begin
                tx_cnt <= '0;
                unique case (tx_state)
                    TX_START: begin
                        tx_state <= TX_DATA;
                        tx_bit   <= '0;
                        stx_q    <= tx_shift[0];
                    end
                    TX_DATA: begin
                        if (tx_bit == {1'b0, tx_nbits} + 3'd4) begin
                            if (parity_enabled(tx_par_cfg)) begin
                                tx_state <= TX_PARITY;
                                stx_q    <= tx_par_bit;
                            end else begin
                                tx_state    <= TX_STOP;
                                tx_stop_idx <= 1'b0;
                                stx_q       <= 1'b1;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= tx_shift >> 1;
                            stx_q    <= tx_shift[1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state    <= TX_STOP;
                        tx_stop_idx <= 1'b0;
                        stx_q       <= 1'b1;
                    end
                    TX_STOP: begin
                        if (tx_stop_idx == tx_stop2) begin
                            tx_state   <= TX_IDLE;
                            tx_ready_q <= 1'b1;
                        end else begin
                            tx_stop_idx <= 1'b1;
                        end
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    assign stx_o      = stx_q;
    assign tx_ready_o = tx_ready_q;
    assign tx_busy_o  = !tx_ready_q;

    // ---------------- receiver ----------------
    rx_state_e     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [1:0]    rx_nbits;
    logic [1:0]    rx_par_cfg;
    logic          rx_par_bit;
    logic          push;
    logic [7:0]    rx_aligned;
    rx_word_t      push_word;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_nbits   <= '0;
            rx_par_cfg <= '0;
            rx_par_bit <= 1'b0;
        end else if (tick) begin
            if (rx_state == RX_IDLE) begin
                if (!rx_s) begin
                    rx_state   <= RX_START;
                    rx_cnt     <= '0;
                    rx_nbits   <= cfg_nbits_i;
                    rx_par_cfg <= cfg_parity_i;
                end
            end else begin
                rx_cnt <= (rx_cnt == CNT_LAST) ? '0 : rx_cnt + 1'b1;
                if (rx_cnt == CNT_MID) begin
                    unique case (rx_state)
                        RX_START:  if (rx_s) rx_state <= RX_IDLE;
                        RX_DATA:   rx_shift <= {rx_s, rx_shift[7:1]};
                        RX_PARITY: rx_par_bit <= rx_s;
                        RX_STOP:   rx_state <= RX_IDLE;
                        default:   rx_state <= RX_IDLE;
                    endcase
                end else if (rx_cnt == CNT_LAST) begin
                    unique case (rx_state)
                        RX_START: begin
                            rx_state <= RX_DATA;
                            rx_bit   <= '0;
                        end
                        RX_DATA: begin
                            if (rx_bit == {1'b0, rx_nbits} + 3'd4)
                                rx_state <= parity_enabled(rx_par_cfg) ? RX_PARITY : RX_STOP;
                            else
                                rx_bit <= rx_bit + 1'b1;
                        end
                        RX_PARITY: rx_state <= RX_STOP;
                        default:   rx_state <= RX_IDLE;
                    endcase
                end
            end
        end
    end

    // Bits arrive LSB first into the top of rx_shift; narrow words are right-justified here.
    assign rx_aligned = rx_shift >> (2'd3 - rx_nbits);
    assign push       = tick && (rx_state == RX_STOP) && (rx_cnt == CNT_MID);
    assign push_word  = '{
        frame_err:  !rx_s,
        parity_err: parity_enabled(rx_par_cfg) &&
                    (parity_of(rx_aligned, rx_nbits) ^ rx_par_bit ^ (rx_par_cfg == PAR_ODD)),
        data:       rx_aligned
    };

    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_rdata;
    rx_word_t          head;
    logic              pop;

    uart_serial_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (rx_ready_i),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head = fifo_rdata;
    assign pop  = rx_ready_i && !fifo_empty;

    logic overrun_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)                         overrun_q <= 1'b0;
        else if (push && fifo_full && !pop)  overrun_q <= 1'b1;
        else if (pop)                        overrun_q <= 1'b0;
    end

    assign rx_valid_o      = !fifo_empty;
    assign rx_data_o       = rx_valid_o ? head.data       : 8'h00;
    assign rx_parity_err_o = rx_valid_o ? head.parity_err : 1'b0;
    assign rx_frame_err_o  = rx_valid_o ? head.frame_err  : 1'b0;
    assign rx_overrun_o    = overrun_q;

endmodule

// File: tb/tb_uart_serial_xcvr.sv
// Directed plus randomized bench for uart_serial_xcvr; the frame model builds
// the expected wire bit list from data, width, parity and stop settings.
module tb_uart_serial_xcvr;

    localparam int BIT_CLKS = 64;  // OVERSAMPLE 16 x (div 3 + 1)

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [15:0] cfg_div_i = 16'd3;
    logic [1:0]  cfg_nbits_i = 2'd3;
    logic [1:0]  cfg_parity_i = 2'd0;
    logic        cfg_stop2_i = 1'b0;
    logic [7:0]  tx_data_i = 8'h00;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic        tx_busy_o;
    logic        stx_o;
    logic        srx_i;
    logic [7:0]  rx_data_o;
    logic        rx_parity_err_o;
    logic        rx_frame_err_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic        rx_overrun_o;

    logic loop_en = 1'b1;
    logic srx_drv = 1'b1;
    assign srx_i = loop_en ? stx_o : srx_drv;

    always #5 clk_i = ~clk_i;

    uart_serial_xcvr dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .cfg_div_i       (cfg_div_i),
        .cfg_nbits_i     (cfg_nbits_i),
        .cfg_parity_i    (cfg_parity_i),
        .cfg_stop2_i     (cfg_stop2_i),
        .tx_data_i       (tx_data_i),
        .tx_valid_i      (tx_valid_i),
        .tx_ready_o      (tx_ready_o),
        .tx_busy_o       (tx_busy_o),
        .stx_o           (stx_o),
        .srx_i           (srx_i),
        .rx_data_o       (rx_data_o),
        .rx_parity_err_o (rx_parity_err_o),
        .rx_frame_err_o  (rx_frame_err_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready_i),
        .rx_overrun_o    (rx_overrun_o)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_bits [$];
    logic wire_q [$];
    int   ready_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Wire image of one frame: start, data LSB first, optional parity, stops.
    task automatic build_frame(input logic [7:0] data, input int code, input int par, input bit stop2);
        int ones;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < code + 5; i++) begin
            exp_bits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (par == 1) exp_bits.push_back(ones % 2 == 1);
        if (par == 2) exp_bits.push_back(ones % 2 == 0);
        exp_bits.push_back(1'b1);
        if (stop2) exp_bits.push_back(1'b1);
    endtask

    task automatic set_cfg(input int code, input int par, input bit stop2);
        @(negedge clk_i);
        cfg_nbits_i  = 2'(code);
        cfg_parity_i = 2'(par);
        cfg_stop2_i  = stop2;
    endtask

    // Accepts one byte and records stx_o every clock until tx_ready_o returns.
    task automatic capture_tx(input logic [7:0] data);
        int idx;
        bit done;
        wire_q.delete();
        done      = 1'b0;
        ready_idx = -1;
        @(negedge clk_i);
        check("tx_ready_before_accept", tx_ready_o, 1);
        tx_data_i  = data;
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        idx = 0;
        while (!done && idx < 4000) begin
            wire_q.push_back(stx_o);
            if (tx_ready_o) begin
                done      = 1'b1;
                ready_idx = idx;
            end else begin
                @(negedge clk_i);
                idx++;
            end
        end
        check("tx_ready_timeout", done, 1);
    endtask

    // Compares the captured wire against exp_bits at each mid-bit point.
    task automatic analyze_frame(input string tag);
        int f;
        f = -1;
        for (int i = 0; i < wire_q.size(); i++)
            if (f < 0 && wire_q[i] == 1'b0) f = i;
        check({tag, "_start_seen"}, f >= 0, 1);
        if (f < 0) f = 0;
        for (int i = 0; i < exp_bits.size(); i++) begin
            int k;
            k = f + BIT_CLKS / 2 + BIT_CLKS * i;
            check($sformatf("%s_bit%0d", tag, i), (k < wire_q.size()) ? wire_q[k] : 1'bx, exp_bits[i]);
        end
        check({tag, "_frame_len"}, ready_idx - f, BIT_CLKS * exp_bits.size());
    endtask

    task automatic pop();
        @(negedge clk_i);
        rx_ready_i = 1'b1;
        @(negedge clk_i);
        rx_ready_i = 1'b0;
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] data, input bit perr, input bit ferr);
        int n;
        n = 0;
        while (!rx_valid_o && n < 4000) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_valid"}, rx_valid_o, 1);
        check({tag, "_data"}, rx_data_o, data);
        check({tag, "_perr"}, rx_parity_err_o, perr);
        check({tag, "_ferr"}, rx_frame_err_o, ferr);
        pop();
    endtask

    task automatic drive_frame();
        loop_en = 1'b0;
        for (int i = 0; i < exp_bits.size(); i++) begin
            srx_drv = exp_bits[i];
            repeat (BIT_CLKS) @(negedge clk_i);
        end
        srx_drv = 1'b1;
    endtask

    initial begin
        int transitions, misaligned, f, n;
        logic [7:0] d;
        int code, par;
        bit stop2;

        // Reset state
        repeat (4) @(negedge clk_i);
        check("rst_stx", stx_o, 1);
        check("rst_tx_ready", tx_ready_o, 1);
        check("rst_tx_busy", tx_busy_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_overrun", rx_overrun_o, 0);
        check("rst_status", {rx_data_o, rx_parity_err_o, rx_frame_err_o}, 0);
        rstn_i = 1'b1;
        repeat (4) @(negedge clk_i);

        // 8N1 0x55 loopback: alternating wire, every edge on a 64-clock grid
        set_cfg(3, 0, 0);
        build_frame(8'h55, 3, 0, 0);
        capture_tx(8'h55);
        analyze_frame("8n1_55");
        transitions = 0;
        misaligned  = 0;
        f = -1;
        for (int i = 1; i < wire_q.size(); i++) begin
            if (wire_q[i] != wire_q[i-1]) begin
                if (f < 0) f = i;
                transitions++;
                if ((i - f) % BIT_CLKS != 0) misaligned++;
            end
        end
        check("8n1_55_transitions", transitions, 10);
        check("8n1_55_misaligned", misaligned, 0);
        check("8n1_55_tx_busy_done", tx_busy_o, 0);
        expect_rx("8n1_55_rx", 8'h55, 0, 0);

        // 7E2 0xA5
        set_cfg(2, 1, 1);
        build_frame(8'hA5, 2, 1, 1);
        capture_tx(8'hA5);
        analyze_frame("7e2_a5");
        expect_rx("7e2_a5_rx", 8'h25, 0, 0);

        // Odd parity, bench-driven 0x3C with inverted parity bit
        set_cfg(3, 2, 0);
        build_frame(8'h3C, 3, 2, 0);
        exp_bits[9] = ~exp_bits[9];
        drive_frame();
        expect_rx("odd_bad_par", 8'h3C, 1, 0);
        loop_en = 1'b1;

        // Break: line held low until a word appears
        set_cfg(3, 0, 0);
        loop_en = 1'b0;
        srx_drv = 1'b0;
        n = 0;
        while (!rx_valid_o && n < 4000) begin
            @(negedge clk_i);
            n++;
        end
        srx_drv = 1'b1;
        expect_rx("break", 8'h00, 0, 1);
        repeat (300) @(negedge clk_i);
        check("break_no_extra", rx_valid_o, 0);

        // Short glitch while idle
        srx_drv = 1'b0;
        repeat (4) @(negedge clk_i);
        srx_drv = 1'b1;
        repeat (300) @(negedge clk_i);
        check("glitch_no_push", rx_valid_o, 0);
        loop_en = 1'b1;

        // Overrun: five bytes into a four-deep FIFO
        for (int i = 1; i <= 5; i++) capture_tx(8'(i));
        repeat (100) @(negedge clk_i);
        check("ovr_set", rx_overrun_o, 1);
        expect_rx("ovr_b1", 8'h01, 0, 0);
        check("ovr_cleared", rx_overrun_o, 0);
        for (int i = 2; i <= 4; i++) expect_rx($sformatf("ovr_b%0d", i), 8'(i), 0, 0);
        check("ovr_drained", rx_valid_o, 0);

        // Reset in the middle of data bit 3
        @(negedge clk_i);
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b1;
        @(negedge clk_i);
        tx_valid_i = 1'b0;
        n = 0;
        while (stx_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        repeat (BIT_CLKS / 2 + BIT_CLKS * 4) @(negedge clk_i);
        check("mid_rst_in_bit3", stx_o, 0);
        #2 rstn_i = 1'b0;
        #1;
        check("mid_rst_stx", stx_o, 1);
        check("mid_rst_tx_ready", tx_ready_o, 1);
        check("mid_rst_tx_busy", tx_busy_o, 0);
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        repeat (700) @(negedge clk_i);
        check("mid_rst_no_push", rx_valid_o, 0);
        build_frame(8'h81, 3, 0, 0);
        capture_tx(8'h81);
        analyze_frame("post_rst_81");
        expect_rx("post_rst_81_rx", 8'h81, 0, 0);

        // Randomized loopback frames
        for (int it = 0; it < 6; it++) begin
            d     = 8'($urandom);
            code  = int'($urandom_range(0, 3));
            par   = int'($urandom_range(0, 3));
            stop2 = 1'($urandom_range(0, 1));
            set_cfg(code, par, stop2);
            build_frame(d, code, par, stop2);
            capture_tx(d);
            analyze_frame($sformatf("rnd%0d", it));
            expect_rx($sformatf("rnd%0d_rx", it), 8'(int'(d) % (1 << (code + 5))), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_serial_xcvr.md
Name: uart_serial_xcvr

Overview:
Parametrised UART transceiver core, successor to the fixed 8N1 serial BFM core.
- Runtime-configurable divisor, data bits (5-8), parity (none/even/odd) and stop bits (1/2).
- Valid/ready byte interfaces on both directions; receive FIFO; parity, framing and overrun status per byte.
- Sits under the UART serial BFM wrapper, between task-level transactors and the srx/stx pads.

Parameters:
DIV_W, 16, width of the oversample clock divisor.
OVERSAMPLE, 16, ticks per bit; power of two, minimum 8.
RX_FIFO_DEPTH, 4, receive FIFO entries; power of two, minimum 2.

Ports:
clk_i  in  1  clock.
rstn_i  in  1  asynchronous active-low reset.
cfg_div_i  in  DIV_W  tick period is cfg_div_i+1 clocks.
cfg_nbits_i  in  2  data bits minus 5.
cfg_parity_i  in  2  00 none, 01 even, 10 odd, 11 treated as none.
cfg_stop2_i  in  1  1 = two stop bits on transmit.
tx_data_i  in  8  transmit byte; only the low nbits are sent.
tx_valid_i  in  1  transmit request.
tx_ready_o  out  1  high only in TX IDLE.
tx_busy_o  out  1  high when TX is not IDLE.
stx_o  out  1  serial output, idle high.
srx_i  in  1  serial input, asynchronous.
rx_data_o  out  8  FIFO head; upper bits zero when nbits<8.
rx_parity_err_o  out  1  FIFO head status.
rx_frame_err_o  out  1  FIFO head status.
rx_valid_o  out  1  FIFO non-empty.
rx_ready_i  in  1  pop FIFO head.
rx_overrun_o  out  1  sticky: a byte was dropped.

Behaviour:
- Reset (rstn_i low, asynchronous): stx_o=1, tx_ready_o=1, tx_busy_o=0, rx_valid_o=0, rx_overrun_o=0, status outputs 0, FIFO empty, both FSMs IDLE, tick counter 0.
- Tick generator: counter runs 0..cfg_div_i, pulses tick for one clock when it wraps. cfg_div_i=0 gives a tick every clock. A divisor change takes effect at the next wrap.
- srx_i passes through a 2-flop synchroniser, reset value 1, giving 2 clocks of latency. All RX logic uses the synchronised value.
- TX accept: tx_valid_i&tx_ready_o on any clock. Accept latches the data, nbits, parity and stop config and enters START; tx_ready_o falls on the next clock.
- TX states: IDLE -> START -> DATA(xnbits, LSB first) -> PARITY (skipped if none) -> STOP (1 or 2 bits) -> IDLE.
- Each TX bit lasts OVERSAMPLE ticks. stx_o changes only on a tick edge. The first tick after accept starts the start bit.
- Parity bit: even = XOR of the sent bits; odd = its inverse.
- Back-to-back TX: tx_ready_o rises the clock after the final stop tick, so a new byte can be accepted with no idle gap beyond that clock.
- RX IDLE: on a tick with rx=0, go to START with cnt=0.
- RX START: at cnt=OVERSAMPLE/2-1, if rx=1 the start is a glitch; return to IDLE and push nothing. At cnt=OVERSAMPLE-1, go to DATA.
- RX DATA and PARITY: sample each bit at its mid-bit count and shift right into the data register.
- RX STOP: sample at mid-bit; frame_err = sample==0. The word {frame_err, parity_err, data} is pushed the same clock and the FSM returns to IDLE.
- RX stop-bit rule: only one stop bit is checked, regardless of cfg_stop2_i.
- Break condition (all zero, stop=0) pushes data 0x00 with frame_err=1.
- Push when FIFO full: the word is dropped and rx_overrun_o is set. It clears on the next successful pop.
- Push and pop in the same clock with FIFO full: pop first, the push succeeds, no overrun.
- FIFO read is first-word-fall-through; pop occurs on rx_valid_o&rx_ready_i.
- RX config is sampled at start-bit detection.
- Reset mid-frame: both FSMs abort immediately; stx_o=1; the partial RX byte is discarded.

Decomposition:
- Package uart_serial_pkg: parity enum (NONE/EVEN/ODD), TX and RX state enums, rx_word_t struct {frame_err, parity_err, data[7:0]}, and a parity function over a byte plus nbits.
- Sub-module uart_serial_rx_fifo: synchronous FIFO of rx_word_t, parametrised depth, with full and empty flags.

Test Plan:
- div=3, 8N1, send 0x55 with stx looped to srx: stx_o holds each bit for 64 clocks; rx_data_o=0x55 with no error flags; tx_ready_o re-rises after 10 bit times.
- 7E2, send 0xA5: wire carries 0,1,0,1,0,0,1,0, parity 1, stop 1,1. RX returns 0x25 with parity_err=0.
- Odd parity configured, bench drives 0x3C with a wrong parity bit: rx_parity_err_o=1, data 0x3C.
- Bench holds srx low for the whole frame: data 0x00, frame_err=1. A 4-clock low glitch while IDLE (div=3) pushes nothing.
- Depth 4, rx_ready_i=0, send 5 bytes 0x01..0x05: rx_overrun_o=1 and FIFO holds 0x01..0x04. The pop of 0x01 clears overrun.
- Assert rstn_i during the DATA bit 3 of a TX byte: stx_o=1 asynchronously, tx_ready_o=1, no RX push; next byte 0x81 completes correctly.
